// File: rtl/prg_arbiter.sv
// Round-robin arbiter sharing one pseudorandom byte generator between GA requesters.
// One PRG transaction at a time; a watchdog aborts a hung PRG with an error response.
module prg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [7:0]         rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               prg_start,
  input  logic [7:0]         prg_value,
  input  logic               prg_done,
  output logic [1:0]         dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_DELIVER = 2'd3;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic [1:0]         r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_grant;
  logic [CNT_W-1:0]   r_wdog;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [7:0]         r_rsp_data;
  logic               r_rsp_err;
  logic               r_busy;
  logic               r_prg_start;

  logic               w_found;
  logic [PTR_W-1:0]   w_pick;
  logic [PTR_W-1:0]   w_next_ptr;
  int                 w_idx;

  // First set request scanning upward from r_rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req[PTR_W'(w_idx)]) begin
        w_found = 1'b1;
        w_pick  = PTR_W'(w_idx);
      end
    end
    w_next_ptr = (w_pick == PTR_W'(NUM_REQ - 1)) ? '0 : w_pick + 1'b1;
  end

  // PRG handshake: prg_start is a one-cycle strobe; the PRG later answers with a
  // one-cycle prg_done carrying prg_value. prg_done is only honoured in WAIT, so
  // stale strobes in any other state are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_wdog      <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_prg_start <= 1'b0;
    end else begin
      r_prg_start <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= w_found;
          if (w_found) begin
            r_grant     <= w_pick;
            r_rr_ptr    <= w_next_ptr;
            r_prg_start <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wdog  <= '0;
          r_busy  <= 1'b1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_wdog <= r_wdog + 1'b1;
          r_busy <= 1'b1;
          // A done on the last watchdog cycle still counts as a good result.
          if (prg_done) begin
            r_rsp_data  <= prg_value;
            r_rsp_valid <= ONE_HOT0 << r_grant;
            r_state     <= ST_DELIVER;
          end else if (r_wdog == CNT_W'(TIMEOUT - 1)) begin
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= ONE_HOT0 << r_grant;
            r_state     <= ST_DELIVER;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign prg_start = r_prg_start;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_prg_arbiter.sv
// Directed bench for prg_arbiter: the PRG is driven by hand, cycle by cycle,
// and every response is checked against hand-computed grants and latencies.
module tb_prg_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       prg_start;
  logic [7:0] prg_value;
  logic       prg_done;
  logic [1:0] dbg_state;

  int total;
  int bad;

  prg_arbiter #(.NUM_REQ(4), .TIMEOUT(64), .CNT_W(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .prg_start (prg_start),
    .prg_value (prg_value),
    .prg_done  (prg_done),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ":valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, ":data"},  32'(rsp_data),  32'h0);
    chk({tag, ":err"},   32'(rsp_err),   32'h0);
    chk({tag, ":busy"},  32'(busy),      32'h0);
    chk({tag, ":start"}, 32'(prg_start), 32'h0);
  endtask

  // One transaction starting from IDLE: req sampled at cycle 0, prg_start at
  // cycle 1, done (if enabled) driven at cycle 1+k, response at cycle 2+k.
  task automatic txn(input logic [3:0] r, input int k, input bit done_en,
                     input bit issue_done, input logic [7:0] v,
                     input logic [3:0] exp_v, input bit exp_err,
                     input logic [7:0] exp_d, input logic [3:0] r_after,
                     input string tag);
    chk({tag, ":idle"}, 32'(dbg_state), 32'd0);
    req = r;
    tick();
    chk({tag, ":start1"}, 32'(prg_start), 32'h1);
    chk({tag, ":busy1"},  32'(busy),      32'h1);
    prg_done  = issue_done;
    prg_value = 8'hFF;
    tick();
    prg_done = 1'b0;
    chk({tag, ":start2"}, 32'(prg_start), 32'h0);
    for (int i = 0; i < k - 1; i++) begin
      tick();
      chk({tag, ":early"}, 32'(rsp_valid), 32'h0);
    end
    prg_done  = done_en;
    prg_value = v;
    tick();
    prg_done  = 1'b0;
    prg_value = 8'h00;
    chk({tag, ":valid"}, 32'(rsp_valid), 32'(exp_v));
    chk({tag, ":data"},  32'(rsp_data),  32'(exp_d));
    chk({tag, ":err"},   32'(rsp_err),   32'(exp_err));
    chk({tag, ":busyd"}, 32'(busy),      32'h1);
    req = r_after;
    tick();
    chk_quiet({tag, ":after"});
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    req       = 4'h0;
    prg_done  = 1'b0;
    prg_value = 8'h00;
    repeat (3) tick();
    chk_quiet("reset");
    chk("reset:state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick();
    chk_quiet("idle0");

    // Round-robin with all requests held: grants 0,1,2,3,0,1,2,3.
    for (int n = 0; n < 8; n++) begin
      logic [3:0] ev;
      ev = 4'b0001 << (n % 4);
      txn(4'b1111, 1 + (n % 3), 1'b1, (n == 5), 8'h10 + 8'(n), ev, 1'b0,
          8'h10 + 8'(n), 4'b1111, $sformatf("rr%0d", n));
    end
    req = 4'h0;
    tick();

    // Single requester, done 4 cycles after start: valid at cycle 6, idle at 7.
    txn(4'b0001, 4, 1'b1, 1'b0, 8'hA5, 4'b0001, 1'b0, 8'hA5, 4'b0000, "single");

    // Wrap: serving 2 leaves rr_ptr=3, so 1001 grants 3 then 0.
    txn(4'b0100, 1, 1'b1, 1'b0, 8'h5A, 4'b0100, 1'b0, 8'h5A, 4'b0000, "wrap2");
    txn(4'b1001, 2, 1'b1, 1'b0, 8'hC3, 4'b1000, 1'b0, 8'hC3, 4'b1001, "wrap3");
    txn(4'b1001, 3, 1'b1, 1'b0, 8'h7E, 4'b0001, 1'b0, 8'h7E, 4'b0000, "wrap0");

    // Timeout: no done, response at cycle 66 with error and zero data.
    txn(4'b0010, 64, 1'b0, 1'b0, 8'hEE, 4'b0010, 1'b1, 8'h00, 4'b0000, "tmo");
    txn(4'b0010, 1, 1'b1, 1'b0, 8'h99, 4'b0010, 1'b0, 8'h99, 4'b0000, "post_tmo");

    // Collision: done on the final watchdog cycle wins.
    txn(4'b0100, 64, 1'b1, 1'b0, 8'h3C, 4'b0100, 1'b0, 8'h3C, 4'b0000, "coll");

    // Stale done in IDLE is discarded.
    prg_done  = 1'b1;
    prg_value = 8'h55;
    tick();
    prg_done  = 1'b0;
    chk("stale:state", 32'(dbg_state), 32'd0);
    chk_quiet("stale");

    // Reset two cycles after prg_start, then a late done pulse.
    req = 4'b0010;
    tick();
    chk("rst:start", 32'(prg_start), 32'h1);
    tick();
    tick();
    chk("rst:wait", 32'(dbg_state), 32'd2);
    reset = 1'b1;
    req   = 4'h0;
    tick();
    chk_quiet("rst:in");
    reset     = 1'b0;
    prg_done  = 1'b1;
    prg_value = 8'h77;
    tick();
    prg_done  = 1'b0;
    prg_value = 8'h00;
    for (int i = 0; i < 3; i++) begin
      chk_quiet($sformatf("rst:post%0d", i));
      chk("rst:state", 32'(dbg_state), 32'd0);
      tick();
    end
    txn(4'b0100, 2, 1'b1, 1'b0, 8'h24, 4'b0100, 1'b0, 8'h24, 4'b0000, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
